fetch_sequencer: RTL and testbench

- Controls the fetch-stage PC register and the F/D/E pipeline registers in the 5-stage pipelined CPU.
- Sequences boot, instruction-memory wait states, branch/jump redirects, trap redirects, halt/resume and load-use hazards.
- Drives the PC register's select, target and stall inputs, plus the pipeline flush/stall controls.
- A redirect that resolves while fetch is blocked is held and applied when fetch can advance.

---
 rtl/fetch_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch-stage control for the 5-stage pipeline.
// Sequences boot, instruction-memory wait states, branch/jump and trap
// redirects, halt/resume and load-use hazards. Drives the PC register
// (redirect_valid/redirect_pc/stall_f) and the F/D, D/E pipeline controls.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   imem_req / imem_ready    instruction memory handshake
//   pcsrc_e, pc_target_e     branch/jump resolved in E
//   trap_req, trap_vector    trap redirect (single-cycle pulse)
//   halt_req, resume         halt / leave HALTED
//   load_e, rd_e, rs1_d, rs2_d  load-use hazard detection
//   redirect_valid/_pc       PC register select and target
//   stall_f, stall_d         hold PC register / F/D register
//   flush_d, flush_e         clear F/D / D/E register
//   halted, mem_timeout      status; timeout is a one-cycle pulse
//
// Optional: define FETCH_PERF_CNT_EN to add perf_stall_cycles and
// perf_redirects (32-bit wrapping event counters).
module fetch_sequencer #(
  parameter int unsigned BOOT_CYCLES = 4,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic        pcsrc_e,
  input  logic [31:0] pc_target_e,
  input  logic        trap_req,
  input  logic [31:0] trap_vector,
  input  logic        halt_req,
  input  logic        resume,
  input  logic        load_e,
  input  logic [4:0]  rd_e,
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        stall_f,
  output logic        stall_d,
  output logic        flush_d,
  output logic        flush_e,
  output logic        halted,
  output logic        mem_timeout
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_redirects
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, MEMWAIT, HALTED} state_t;

  state_t      state, state_nxt;
  logic [7:0]  boot_cnt, boot_cnt_nxt;
  logic [15:0] wait_cnt, wait_cnt_nxt;
  logic        pending, pending_nxt;
  logic        pending_trap, pending_trap_nxt;
  logic [31:0] pending_pc, pending_pc_nxt;
  logic        halt_latch, halt_latch_nxt;

  logic advance;   // fetch can advance this cycle
  logic capture;   // redirects must be parked in pending
  logic load_use;

  assign load_use = load_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= BOOT;
      boot_cnt     <= '0;
      wait_cnt     <= '0;
      pending      <= 1'b0;
      pending_trap <= 1'b0;
      pending_pc   <= '0;
      halt_latch   <= 1'b0;
    end else begin
      state        <= state_nxt;
      boot_cnt     <= boot_cnt_nxt;
      wait_cnt     <= wait_cnt_nxt;
      pending      <= pending_nxt;
      pending_trap <= pending_trap_nxt;
      pending_pc   <= pending_pc_nxt;
      halt_latch   <= halt_latch_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    boot_cnt_nxt     = boot_cnt;
    wait_cnt_nxt     = wait_cnt;
    pending_nxt      = pending;
    pending_trap_nxt = pending_trap;
    pending_pc_nxt   = pending_pc;
    halt_latch_nxt   = halt_latch;
    imem_req         = 1'b0;
    redirect_valid   = 1'b0;
    redirect_pc      = '0;
    stall_f          = 1'b0;
    stall_d          = 1'b0;
    flush_d          = 1'b0;
    flush_e          = 1'b0;
    halted           = 1'b0;
    mem_timeout      = 1'b0;
    advance          = 1'b0;
    capture          = 1'b0;

    unique case (state)
      BOOT: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        // Held low while rst is asserted so the reset-time outputs are clean.
        flush_d = !rst;
        if (boot_cnt == 8'(BOOT_CYCLES - 1)) state_nxt = RUN;
        else boot_cnt_nxt = boot_cnt + 8'd1;
      end
      RUN: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          advance = 1'b1;
        end else begin
          capture      = 1'b1;
          state_nxt    = MEMWAIT;
          wait_cnt_nxt = '0;
        end
      end
      MEMWAIT: begin
        imem_req    = 1'b1;
        mem_timeout = (wait_cnt == 16'(MEM_TIMEOUT - 1));
        // Saturate so the timeout pulses only once per wait.
        if (wait_cnt != 16'(MEM_TIMEOUT)) wait_cnt_nxt = wait_cnt + 16'd1;
        if (imem_ready) advance = 1'b1;
        else            capture = 1'b1;
      end
      HALTED: begin
        halted  = 1'b1;
        capture = 1'b1;
        if (resume) state_nxt = RUN;
      end
      default: state_nxt = BOOT;
    endcase

    if (capture) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
      if (state != HALTED && halt_req) halt_latch_nxt = 1'b1;
      // A parked trap is never displaced by a later branch.
      if (trap_req) begin
        pending_nxt      = 1'b1;
        pending_trap_nxt = 1'b1;
        pending_pc_nxt   = trap_vector;
      end else if (pcsrc_e && !pending_trap) begin
        pending_nxt    = 1'b1;
        pending_pc_nxt = pc_target_e;
      end
    end

    if (advance) begin
      if (trap_req) begin
        redirect_valid = 1'b1;
        redirect_pc    = trap_vector;
      end else if (pcsrc_e) begin
        redirect_valid = 1'b1;
        redirect_pc    = pc_target_e;
      end else if (pending) begin
        redirect_valid = 1'b1;
        redirect_pc    = pending_pc;
      end

      // Any redirect supersedes a parked one.
      if (redirect_valid) begin
        flush_d          = 1'b1;
        flush_e          = 1'b1;
        pending_nxt      = 1'b0;
        pending_trap_nxt = 1'b0;
      end else if (load_use) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end

      halt_latch_nxt = 1'b0;
      state_nxt      = (halt_req || halt_latch) ? HALTED : RUN;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_redirects    <= '0;
    end else begin
      if (stall_f && state != BOOT) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (redirect_valid)           perf_redirects    <= perf_redirects + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic        imem_ready;
  logic        pcsrc_e;
  logic [31:0] pc_target_e;
  logic        trap_req;
  logic [31:0] trap_vector;
  logic        halt_req;
  logic        resume;
  logic        load_e;
  logic [4:0]  rd_e;
  logic [4:0]  rs1_d;
  logic [4:0]  rs2_d;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall_f;
  logic        stall_d;
  logic        flush_d;
  logic        flush_e;
  logic        halted;
  logic        mem_timeout;

  int vectors;
  int miscompares;

  string       tag_q[$];
  logic [39:0] exp_q[$];

  fetch_sequencer #(.BOOT_CYCLES(4), .MEM_TIMEOUT(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_ready     (imem_ready),
    .pcsrc_e        (pcsrc_e),
    .pc_target_e    (pc_target_e),
    .trap_req       (trap_req),
    .trap_vector    (trap_vector),
    .halt_req       (halt_req),
    .resume         (resume),
    .load_e         (load_e),
    .rd_e           (rd_e),
    .rs1_d          (rs1_d),
    .rs2_d          (rs2_d),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall_f        (stall_f),
    .stall_d        (stall_d),
    .flush_d        (flush_d),
    .flush_e        (flush_e),
    .halted         (halted),
    .mem_timeout    (mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {imem_req, redirect_valid, stall_f, stall_d, flush_d, flush_e, halted, mem_timeout, redirect_pc}
  function automatic logic [39:0] ev(input logic req, rv, sf, sd, fd, fe, h, mt,
                                     input logic [31:0] pc);
    return {req, rv, sf, sd, fd, fe, h, mt, pc};
  endfunction

  task automatic check_val(input string tag, input logic [39:0] got, input logic [39:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      string       t;
      logic [39:0] e;
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check_val(t, {imem_req, redirect_valid, stall_f, stall_d, flush_d, flush_e,
                    halted, mem_timeout, redirect_pc}, e);
    end
  end

  task automatic idle();
    imem_ready  = 1'b1;
    pcsrc_e     = 1'b0;
    pc_target_e = '0;
    trap_req    = 1'b0;
    trap_vector = '0;
    halt_req    = 1'b0;
    resume      = 1'b0;
    load_e      = 1'b0;
    rd_e        = '0;
    rs1_d       = '0;
    rs2_d       = '0;
  endtask

  // Queue the expectation for the current cycle, then move past the next edge.
  task automatic cyc(input string tag, input logic [39:0] e);
    tag_q.push_back(tag);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  logic [39:0] run_idle, blocked, halt_out, boot_out, rst_out;

  initial begin
    vectors     = 0;
    miscompares = 0;
    run_idle = ev(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    blocked  = ev(1, 0, 1, 1, 0, 1, 0, 0, 32'h0);
    halt_out = ev(0, 0, 1, 1, 0, 1, 1, 0, 32'h0);
    boot_out = ev(0, 0, 1, 1, 1, 0, 0, 0, 32'h0);
    rst_out  = ev(0, 0, 1, 1, 0, 0, 0, 0, 32'h0);
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;
    cyc("reset", rst_out);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) cyc("boot", boot_out);
    cyc("run_first", run_idle);

    pcsrc_e = 1'b1; pc_target_e = 32'h0000_0100;
    cyc("branch", ev(1, 1, 0, 0, 1, 1, 0, 0, 32'h100));

    idle(); load_e = 1'b1; rd_e = 5'd5; rs2_d = 5'd5;
    cyc("load_use_rs2", blocked);
    idle(); load_e = 1'b1; rd_e = 5'd7; rs1_d = 5'd7;
    cyc("load_use_rs1", blocked);
    idle(); load_e = 1'b1; rd_e = 5'd0; rs1_d = 5'd0; rs2_d = 5'd0;
    cyc("load_rd0", run_idle);
    idle(); load_e = 1'b1; rd_e = 5'd3; rs1_d = 5'd3; pcsrc_e = 1'b1; pc_target_e = 32'h44;
    cyc("load_use_redir", ev(1, 1, 0, 0, 1, 1, 0, 0, 32'h44));

    idle(); imem_ready = 1'b0; pcsrc_e = 1'b1; pc_target_e = 32'h200;
    cyc("wait0", blocked);
    idle(); imem_ready = 1'b0;
    cyc("wait1", blocked);
    cyc("wait2", blocked);
    idle();
    cyc("wait_done", ev(1, 1, 0, 0, 1, 1, 0, 0, 32'h200));
    cyc("pend_cleared", run_idle);

    trap_req = 1'b1; trap_vector = 32'h8000_0000; pcsrc_e = 1'b1; pc_target_e = 32'h40;
    cyc("trap_prio", ev(1, 1, 0, 0, 1, 1, 0, 0, 32'h8000_0000));

    idle(); imem_ready = 1'b0; pcsrc_e = 1'b1; pc_target_e = 32'h500;
    cyc("park_br", blocked);
    idle(); imem_ready = 1'b0; trap_req = 1'b1; trap_vector = 32'h600;
    cyc("park_trap", blocked);
    idle(); imem_ready = 1'b0; pcsrc_e = 1'b1; pc_target_e = 32'h700;
    cyc("park_br2", blocked);
    idle();
    cyc("park_apply", ev(1, 1, 0, 0, 1, 1, 0, 0, 32'h600));

    halt_req = 1'b1;
    cyc("halt_req", run_idle);
    idle(); pcsrc_e = 1'b1; pc_target_e = 32'h300;
    cyc("halted0", halt_out);
    idle();
    cyc("halted1", halt_out);
    resume = 1'b1; halt_req = 1'b1;
    cyc("resume", halt_out);
    idle();
    cyc("resume_redir", ev(1, 1, 0, 0, 1, 1, 0, 0, 32'h300));

    halt_req = 1'b1; pcsrc_e = 1'b1; pc_target_e = 32'h900;
    cyc("halt_redir", ev(1, 1, 0, 0, 1, 1, 0, 0, 32'h900));
    idle();
    cyc("halted2", halt_out);
    resume = 1'b1;
    cyc("resume2", halt_out);
    idle();
    cyc("no_stale", run_idle);

    imem_ready = 1'b0;
    cyc("mw_halt0", blocked);
    idle(); imem_ready = 1'b0; halt_req = 1'b1;
    cyc("mw_halt1", blocked);
    idle();
    cyc("mw_halt_done", run_idle);
    cyc("mw_halted", halt_out);
    resume = 1'b1;
    cyc("resume3", halt_out);
    idle();
    cyc("run_again", run_idle);

    imem_ready = 1'b0;
    cyc("to_enter", blocked);
    for (int i = 1; i <= 10; i++)
      cyc("timeout", ev(1, 0, 1, 1, 0, 1, 0, (i == 8) ? 1'b1 : 1'b0, 32'h0));
    idle();
    cyc("to_done", run_idle);

    imem_ready = 1'b0; pcsrc_e = 1'b1; pc_target_e = 32'hA00;
    cyc("pre_rst0", blocked);
    idle(); imem_ready = 1'b0;
    cyc("pre_rst1", blocked);
    rst = 1'b1;
    idle();
    cyc("mid_rst", rst_out);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc("reboot", boot_out);
    cyc("rst_no_pend", run_idle);
    cyc("rst_run", run_idle);

    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d unchecked expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
